// File: rtl/instr_fetch_decode.sv
// Program-memory reader: owns the PC, registers the ROM word and presents its
// decoded fields to execute over a valid/ready handshake.
module instr_fetch_decode #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 35,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [3:0]         opcode,
  output logic [2:0]         func,
  output logic [1:0]         s1_type,
  output logic [7:0]         s1_val,
  output logic [1:0]         s2_type,
  output logic [7:0]         s2_val,
  output logic [7:0]         target,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               is_nop
);

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] func;
    logic [1:0] s1_type;
    logic [7:0] s1_val;
    logic [1:0] s2_type;
    logic [7:0] s2_val;
    logic [7:0] target;
  } instr_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, ir_pc;
  logic [INSTR_W-1:0]  ir;
  instr_t              f;
  logic                load, take;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   state_nxt = FULL;
      FULL:    if (instr_ready && redirect) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // load: capture rom_data and advance; take: accepted redirect, drop the word on rom_data
  always_comb begin
    instr_valid = (state == FULL);
    take        = (state == FULL) && instr_ready && redirect;
    load        = (state == EMPTY) || ((state == FULL) && instr_ready && !redirect);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      ir    <= '0;
      ir_pc <= '0;
    end else if (take) begin
      pc    <= redirect_addr;
    end else if (load) begin
      ir    <= rom_data;
      ir_pc <= pc;
      pc    <= pc + 1'b1;
    end
  end

  // ROM address comes straight from the PC register to keep the ROM path reg-to-reg
  assign rom_addr = pc;
  assign instr_pc = ir_pc;
  assign f        = ir;
  assign opcode   = f.opcode;
  assign func     = f.func;
  assign s1_type  = f.s1_type;
  assign s1_val   = f.s1_val;
  assign s2_type  = f.s2_type;
  assign s2_val   = f.s2_val;
  assign target   = f.target;
  assign is_nop   = (ir == '0);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed plan items plus randomized handshake
// traffic scored against a cycle-level model of the fetch rules.
module tb_instr_fetch_decode;
  logic        clk;
  logic        reset, instr_ready, redirect;
  logic [7:0]  redirect_addr, rom_addr, instr_pc;
  logic [34:0] rom_data;
  logic        instr_valid, is_nop;
  logic [3:0]  opcode;
  logic [2:0]  func;
  logic [1:0]  s1_type, s2_type;
  logic [7:0]  s1_val, s2_val, target;

  logic [34:0] rom [256];
  int n_chk, n_err;

  // model state: next fetch address, whether an instruction is presented, and which
  logic [7:0]  m_pc, m_ipc;
  logic [34:0] m_ir;
  bit          m_valid;

  localparam logic [34:0] W0 = {4'h1, 3'h0, 2'h1, 8'hAA, 2'h0, 8'h55, 8'h07};

  instr_fetch_decode dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_addr(redirect_addr), .opcode(opcode), .func(func),
    .s1_type(s1_type), .s1_val(s1_val), .s2_type(s2_type), .s2_val(s2_val),
    .target(target), .instr_pc(instr_pc), .is_nop(is_nop)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid", instr_valid, m_valid);
    chk("rom_addr", rom_addr, m_pc);
    if (m_valid) begin
      chk("instr_pc", instr_pc, m_ipc);
      chk("opcode",  opcode,  (m_ir >> 31) % 16);
      chk("func",    func,    (m_ir >> 28) % 8);
      chk("s1_type", s1_type, (m_ir >> 26) % 4);
      chk("s1_val",  s1_val,  (m_ir >> 18) % 256);
      chk("s2_type", s2_type, (m_ir >> 16) % 4);
      chk("s2_val",  s2_val,  (m_ir >> 8) % 256);
      chk("target",  target,  m_ir % 256);
      chk("is_nop",  is_nop,  m_ir == 0);
    end
  endtask

  // one clock: drive at negedge, advance the model, check just after the edge
  task automatic cyc(input bit rst, input bit rdy, input bit rd, input logic [7:0] ra);
    @(negedge clk);
    reset = rst; instr_ready = rdy; redirect = rd; redirect_addr = ra;
    if (rst) begin
      m_pc = 8'h00; m_valid = 0; m_ir = '0; m_ipc = 8'h00;
    end else if (!m_valid || (rdy && !rd)) begin
      m_ir = rom[m_pc]; m_ipc = m_pc; m_pc = m_pc + 8'd1; m_valid = 1;
    end else if (rdy && rd) begin
      m_pc = ra; m_valid = 0;
    end
    @(posedge clk); #1;
    check_model();
  endtask

  initial begin
    logic [3:0]  h_op;
    logic [7:0]  h_pc, h_s1, h_s2, h_tg;
    n_chk = 0; n_err = 0;
    reset = 1; instr_ready = 0; redirect = 0; redirect_addr = 0;
    m_pc = 0; m_ipc = 0; m_ir = '0; m_valid = 0;
    for (int i = 0; i < 256; i++) rom[i] = W0;

    // reset state
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 8'h44);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_nop", is_nop, 1'b1);
    chk("rst_addr", rom_addr, 8'h00);

    // free run, first instruction one cycle after reset release
    cyc(0, 1, 0, 0);
    chk("fr_valid", instr_valid, 1'b1);
    chk("fr_pc0", instr_pc, 8'h00);
    chk("fr_op", opcode, 4'h1);
    chk("fr_s1", s1_val, 8'hAA);
    chk("fr_s2", s2_val, 8'h55);
    chk("fr_tgt", target, 8'h07);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("fr_pc", instr_pc, 8'(i));
    end

    // redirect at pc 3 to 8: one bubble
    cyc(0, 1, 1, 8'h08);
    chk("rd_bubble", instr_valid, 1'b0);
    chk("rd_addr", rom_addr, 8'h08);
    cyc(0, 1, 0, 0);
    chk("rd_valid", instr_valid, 1'b1);
    chk("rd_pc", instr_pc, 8'h08);

    // stall at pc 5
    cyc(1, 0, 0, 0);
    for (int i = 0; i <= 5; i++) cyc(0, 1, 0, 0);
    chk("st_pc5", instr_pc, 8'h05);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("st_hold_pc", instr_pc, 8'h05);
      chk("st_hold_addr", rom_addr, 8'h06);
      chk("st_hold_v", instr_valid, 1'b1);
    end
    cyc(0, 1, 0, 0);
    chk("st_next", instr_pc, 8'h06);

    // redirect while stalled is ignored
    cyc(0, 0, 1, 8'h40);
    chk("rs_pc", instr_pc, 8'h06);
    chk("rs_addr", rom_addr, 8'h07);
    cyc(0, 1, 0, 0);
    chk("rs_seq", instr_pc, 8'h07);

    // wrap FE, FF, 00, 01
    cyc(0, 1, 1, 8'hFE);
    cyc(0, 1, 0, 0); chk("wr_fe", instr_pc, 8'hFE);
    cyc(0, 1, 0, 0); chk("wr_ff", instr_pc, 8'hFF);
    cyc(0, 1, 0, 0); chk("wr_00", instr_pc, 8'h00);
    cyc(0, 1, 0, 0); chk("wr_01", instr_pc, 8'h01);

    // reset during a redirect, then a NOP word at address 0
    rom[0] = '0;
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 8'h30);
    chk("rr_valid", instr_valid, 1'b0);
    chk("rr_addr", rom_addr, 8'h00);
    cyc(0, 1, 0, 0);
    chk("nop_flag", is_nop, 1'b1);
    chk("nop_op", opcode, 4'h0);

    // self-loop redirect: one bubble per iteration at the same pc
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 8'h20);
      cyc(0, 1, 0, 0);
      chk("loop_pc", instr_pc, 8'h20);
    end

    // randomized traffic against the model
    for (int i = 0; i < 256; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? 35'd0 : {$urandom, $urandom} % (64'd1 << 35);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 6) == 0, 8'($urandom));
    end

    // stalled outputs must not move even across random redirect requests
    cyc(0, 1, 0, 0);
    h_pc = instr_pc; h_op = opcode; h_s1 = s1_val; h_s2 = s2_val; h_tg = target;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, i[0], 8'($urandom));
      chk("hold_pc", instr_pc, h_pc);
      chk("hold_op", opcode, h_op);
      chk("hold_f", {h_s1, h_s2, h_tg}, {s1_val, s2_val, target});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
